// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state type, LFSR/MISR constants and step functions
package adder_bist_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} bist_state_t;
  localparam logic [23:0] LFSR_INIT_LO = 24'hCE1AB5;
  localparam int LFSR_TAPS [4] = '{31, 21, 1, 0};
  localparam int MISR_TAPS [4] = '{15, 14, 12, 3};
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {q[30:0], q[LFSR_TAPS[0]] ^ q[LFSR_TAPS[1]] ^ q[LFSR_TAPS[2]] ^ q[LFSR_TAPS[3]]};
  endfunction
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], s[MISR_TAPS[0]] ^ s[MISR_TAPS[1]] ^ s[MISR_TAPS[2]] ^ s[MISR_TAPS[3]]} ^ d;
  endfunction
endpackage

// File: rtl/bist_lfsr32.sv
// bist_lfsr32: 32-bit Fibonacci LFSR with load and advance controls
module bist_lfsr32
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] load_val,
  output logic [31:0] q
);
  // load has priority so a new run always starts from the seeded value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= load ? load_val : adv ? lfsr_next(q) : q;
endmodule

// File: rtl/adder_bist.sv
// adder_bist: LFSR-driven self-test of the CLA/RCA pair with MISR signature
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NUM_VECTORS   = 256,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seed,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   cla_z,
  input  logic [WIDTH:0]   rca_z,
  input  logic             byte_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       sig_byte
);
  bist_state_t state;
  logic        start_q;
  logic [15:0] sig;
  logic [15:0] vec_cnt;
  logic [3:0]  settle_cnt;
  logic [31:0] lfsr;
  logic [16:0] cz;
  logic [15:0] d;
  logic        start_edge;
  logic        load;
  logic        adv;
  assign start_edge = start & ~start_q;
  assign load       = !abort && start_edge && (state == IDLE || state == DONE);
  assign adv        = !abort && state == CAPTURE;
  assign cz         = 17'(cla_z);
  assign d          = cz[15:0] ^ {15'b0, cz[16]};
  assign a          = lfsr[WIDTH-1:0];
  assign b          = lfsr[WIDTH+15:16];
  assign busy       = state == APPLY || state == CAPTURE;
  assign done       = state == DONE;
  assign pass       = done && err_count == 8'd0;
  bist_lfsr32 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .adv      (adv),
    .load_val ({seed, LFSR_INIT_LO}),
    .q        (lfsr)
  );
  // run sequencing, mismatch counting, signature compaction and byte readout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      sig        <= '0;
      err_count  <= '0;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      sig_byte   <= '0;
    end else begin
      start_q  <= start;
      sig_byte <= byte_sel ? sig[15:8] : sig[7:0];
      if (abort) state <= IDLE;
      else
        case (state)
          IDLE, DONE:
            if (start_edge) begin
              sig        <= '0;
              err_count  <= '0;
              vec_cnt    <= '0;
              settle_cnt <= '0;
              state      <= APPLY;
            end
          APPLY: begin
            settle_cnt <= settle_cnt == 4'(SETTLE_CYCLES - 1) ? 4'd0 : settle_cnt + 4'd1;
            state      <= settle_cnt == 4'(SETTLE_CYCLES - 1) ? CAPTURE : APPLY;
          end
          CAPTURE: begin
            err_count <= (cla_z != rca_z && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
            sig       <= misr_next(sig, d);
            vec_cnt   <= vec_cnt + 16'd1;
            state     <= vec_cnt == 16'(NUM_VECTORS - 1) ? DONE : APPLY;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed table-driven check of adder_bist runs, abort, reset and saturation
module tb_adder_bist;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start4 = 1'b0, abort4 = 1'b0, bsel4 = 1'b0, fault4 = 1'b0;
  logic [7:0]  seed4 = 8'h00;
  logic [15:0] a4, b4;
  logic [16:0] cla4, rca4;
  logic        busy4, done4, pass4;
  logic [7:0]  err4, sb4;
  logic        start3 = 1'b0, abort3 = 1'b0, bsel3 = 1'b0;
  logic [7:0]  seed3 = 8'h42;
  logic [15:0] a3, b3;
  logic [16:0] cla3, rca3;
  logic        busy3, done3, pass3;
  logic [7:0]  err3, sb3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign cla4 = {1'b0, a4} + {1'b0, b4};
  assign rca4 = cla4 ^ {16'b0, fault4};
  assign cla3 = {1'b0, a3} + {1'b0, b3};
  assign rca3 = ~cla3;

  adder_bist #(.WIDTH(16), .NUM_VECTORS(4), .SETTLE_CYCLES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .seed(seed4),
    .a(a4), .b(b4), .cla_z(cla4), .rca_z(rca4), .byte_sel(bsel4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .sig_byte(sb4)
  );

  adder_bist #(.WIDTH(16), .NUM_VECTORS(300), .SETTLE_CYCLES(1)) u300 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .seed(seed3),
    .a(a3), .b(b3), .cla_z(cla3), .rca_z(rca3), .byte_sel(bsel3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .sig_byte(sb3)
  );

  typedef struct {
    logic [7:0]  seed;
    int          k;
    logic [7:0]  e_err;
    logic        e_pass;
    logic [15:0] a0, b0, a1, b1;
  } row_t;
  row_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sig_model(input logic [7:0] sd, input int n);
    logic [31:0] l;
    logic [15:0] s;
    logic [16:0] z;
    l = {sd, 24'hCE1AB5};
    s = '0;
    for (int i = 0; i < n; i++) begin
      z = {1'b0, l[15:0]} + {1'b0, l[31:16]};
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ z[15:0] ^ {15'b0, z[16]};
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
    return s;
  endfunction

  task automatic kick4(input logic [7:0] sd);
    @(negedge clk);
    seed4  = sd;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic step4(input int cyc, input int k);
    fault4 = (k >= 0 && cyc == 2 * k + 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] es;
    int done_at;
    tbl[0] = '{8'h00, -1, 8'd0, 1'b1, 16'h1AB5, 16'h00CE, 16'h356B, 16'h019C};
    tbl[1] = '{8'h00,  2, 8'd1, 1'b0, 16'h1AB5, 16'h00CE, 16'h356B, 16'h019C};
    tbl[2] = '{8'hA5, -1, 8'd0, 1'b1, 16'h1AB5, 16'hA5CE, 16'h356A, 16'h4B9C};
    tbl[3] = '{8'hFF,  0, 8'd1, 1'b0, 16'h1AB5, 16'hFFCE, 16'h356A, 16'hFF9C};
    tbl[4] = '{8'h3C,  3, 8'd1, 1'b0, 16'h1AB5, 16'h3CCE, 16'h356B, 16'h799C};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a", a4, 0);
    chk("rst_b", b4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_pass", pass4, 0);
    chk("rst_err", err4, 0);
    chk("rst_sigbyte", sb4, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      kick4(tbl[r].seed);
      chk($sformatf("row%0d_a0", r), a4, tbl[r].a0);
      chk($sformatf("row%0d_b0", r), b4, tbl[r].b0);
      done_at = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        step4(cyc, tbl[r].k);
        if (cyc == 1) chk($sformatf("row%0d_busy", r), busy4, 1);
        if (cyc == 2) begin
          chk($sformatf("row%0d_a1", r), a4, tbl[r].a1);
          chk($sformatf("row%0d_b1", r), b4, tbl[r].b1);
        end
        if (done4) begin
          done_at = cyc;
          break;
        end
      end
      fault4 = 1'b0;
      es = sig_model(tbl[r].seed, 4);
      chk($sformatf("row%0d_done_time", r), done_at, 8);
      chk($sformatf("row%0d_err", r), err4, tbl[r].e_err);
      chk($sformatf("row%0d_pass", r), pass4, tbl[r].e_pass);
      bsel4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_sig_lo", r), sb4, es[7:0]);
      bsel4 = 1'b1;
      #1 chk($sformatf("row%0d_sig_latency", r), sb4, es[7:0]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_sig_hi", r), sb4, es[15:8]);
      chk($sformatf("row%0d_done_hold", r), done4, 1);
    end

    kick4(8'h11);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc == 3) abort4 = 1'b1;
      step4(cyc, 0);
    end
    abort4 = 1'b0;
    fault4 = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_err_hold", err4, 1);

    kick4(8'h00);
    done_at = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 3) start4 = 1'b1;
      if (cyc == 5) start4 = 1'b0;
      step4(cyc, -1);
      if (done4) begin
        done_at = cyc;
        break;
      end
    end
    start4 = 1'b0;
    es = sig_model(8'h00, 4);
    chk("restart_done_time", done_at, 8);
    chk("restart_err", err4, 0);
    chk("restart_pass", pass4, 1);
    @(posedge clk);
    @(negedge clk);
    chk("restart_sig_hi", sb4, es[15:8]);

    kick4(8'h5A);
    for (int cyc = 1; cyc <= 3; cyc++) step4(cyc, 0);
    fault4 = 1'b0;
    chk("pre_reset_err", err4, 1);
    chk("pre_reset_busy", busy4, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a", a4, 0);
    chk("async_rst_b", b4, 0);
    chk("async_rst_busy", busy4, 0);
    chk("async_rst_err", err4, 0);
    chk("async_rst_sigbyte", sb4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    done_at = 0;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done3) begin
        done_at = cyc;
        break;
      end
    end
    chk("sat_done_time", done_at, 600);
    chk("sat_err", err3, 255);
    chk("sat_pass", pass3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
